// File: rtl/hxmpp_hit_store_pkg.sv
// Shared widths and types for the HXM per-SSID hit store.
package hxmpp_hit_store_pkg;

   localparam int unsigned DEF_ROWINDEXBITS_HNM = 4;
   localparam int unsigned DEF_COLINDEXBITS_HNM = 4;
   localparam int unsigned DEF_HITINFOBITS      = 8;
   localparam int unsigned DEF_MAXHITS          = 4;

   typedef enum logic {StIdle, StStream} readState_t;

endpackage

// File: rtl/hxmpp_hit_mem.sv
// Simple dual-port hit-info memory: one write port, one registered read port.
module hxmpp_hit_mem #(
   parameter int unsigned ADDRBITS = 10,
   parameter int unsigned DATABITS = 8
) (
   input  logic                clk,
   input  logic                we,
   input  logic [ADDRBITS-1:0] wAddr,
   input  logic [DATABITS-1:0] wData,
   input  logic                re,
   input  logic [ADDRBITS-1:0] rAddr,
   output logic [DATABITS-1:0] rData
);

   logic [DATABITS-1:0] mem [2**ADDRBITS];

   always_ff @(posedge clk) begin
      if (we) mem[wAddr] <= wData;
      if (re) rData <= mem[rAddr];
   end

endmodule

// File: rtl/hxmpp_hit_store.sv
// Per-SSID hit store: counts and keeps up to MAXHITS hit-info words per SSID and
// streams them back oldest-first on request.
module hxmpp_hit_store
   import hxmpp_hit_store_pkg::*;
#(
   parameter int unsigned ROWINDEXBITS_HNM = DEF_ROWINDEXBITS_HNM,
   parameter int unsigned COLINDEXBITS_HNM = DEF_COLINDEXBITS_HNM,
   parameter int unsigned SSIDBITS         = ROWINDEXBITS_HNM + COLINDEXBITS_HNM,
   parameter int unsigned ROWINDEXBITS_HCM = SSIDBITS,
   parameter int unsigned HITINFOBITS      = DEF_HITINFOBITS,
   parameter int unsigned MAXHITS          = DEF_MAXHITS
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        write,
   input  logic [ROWINDEXBITS_HCM-1:0] writeSSID,
   input  logic [HITINFOBITS-1:0]      writeHitInfo,
   input  logic                        read,
   input  logic [ROWINDEXBITS_HCM-1:0] readSSID,
   output logic [SSIDBITS-1:0]         SSID_read,
   output logic [HITINFOBITS-1:0]      hitInfo_read,
   output logic                        dataValid_read,
   output logic                        busy_read
);

   localparam int unsigned CNTBITS  = $clog2(MAXHITS + 1);
   localparam int unsigned SLOTBITS = (MAXHITS > 1) ? $clog2(MAXHITS) : 1;
   localparam int unsigned NSSID    = 2 ** SSIDBITS;
   localparam logic [CNTBITS-1:0] MaxCnt = CNTBITS'(MAXHITS);

   logic [CNTBITS-1:0] nHits [NSSID];

   logic [CNTBITS-1:0] wrCnt;
   logic               wrAccept;

   assign wrCnt    = nHits[SSIDBITS'(writeSSID)];
   assign wrAccept = write && (wrCnt < MaxCnt);

   // Full SSIDs keep their count saturated; the extra hit is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NSSID; i++) nHits[i] <= '0;
      end else if (wrAccept) begin
         nHits[SSIDBITS'(writeSSID)] <= wrCnt + CNTBITS'(1);
      end
   end

   readState_t          stateQ, stateD;
   logic [SSIDBITS-1:0] ssidQ, ssidD;
   logic [CNTBITS-1:0]  nQ, nD;
   logic [CNTBITS-1:0]  idxQ, idxD;
   logic                validQ;
   logic                rdEn;
   logic [CNTBITS-1:0]  rdCnt;

   assign rdCnt = nHits[SSIDBITS'(readSSID)];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ <= StIdle;
         ssidQ  <= '0;
         nQ     <= '0;
         idxQ   <= '0;
         validQ <= 1'b0;
      end else begin
         stateQ <= stateD;
         ssidQ  <= ssidD;
         nQ     <= nD;
         idxQ   <= idxD;
         validQ <= rdEn;
      end
   end

   always_comb begin
      stateD = stateQ;
      ssidD  = ssidQ;
      nD     = nQ;
      idxD   = idxQ;
      rdEn   = 1'b0;
      unique case (stateQ)
         StIdle: begin
            // Count is sampled here, so later writes to this SSID are not streamed.
            if (read && (rdCnt != '0)) begin
               ssidD  = SSIDBITS'(readSSID);
               nD     = rdCnt;
               idxD   = '0;
               stateD = StStream;
            end
         end
         StStream: begin
            rdEn = 1'b1;
            idxD = idxQ + CNTBITS'(1);
            if (idxQ == nQ - CNTBITS'(1)) stateD = StIdle;
         end
         default: stateD = StIdle;
      endcase
   end

   logic [HITINFOBITS-1:0] memData;

   hxmpp_hit_mem #(
      .ADDRBITS (SSIDBITS + SLOTBITS),
      .DATABITS (HITINFOBITS)
   ) u_mem (
      .clk   (clk),
      .we    (wrAccept),
      .wAddr ({SSIDBITS'(writeSSID), wrCnt[SLOTBITS-1:0]}),
      .wData (writeHitInfo),
      .re    (rdEn),
      .rAddr ({ssidQ, idxQ[SLOTBITS-1:0]}),
      .rData (memData)
   );

   assign dataValid_read = validQ;
   assign SSID_read      = validQ ? ssidQ : '0;
   assign hitInfo_read   = validQ ? memData : '0;
   assign busy_read      = (stateQ == StStream) || validQ;

endmodule

// File: tb/tb_hxmpp_hit_store.sv
// Scoreboard bench for hxmpp_hit_store: a reference model predicts each stream.
module tb_hxmpp_hit_store;

   typedef struct {
      logic [7:0] ssid;
      logic [7:0] info;
      int         cyc;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       write;
   logic [7:0] writeSSID;
   logic [7:0] writeHitInfo;
   logic       read;
   logic [7:0] readSSID;
   logic [7:0] SSID_read;
   logic [7:0] hitInfo_read;
   logic       dataValid_read;
   logic       busy_read;

   int         nCompared = 0;
   int         nMismatch = 0;
   int         cyc = 0;
   exp_t       sb[$];
   int         mCnt [256];
   logic [7:0] mMem [256][4];

   hxmpp_hit_store u_dut (
      .clk            (clk),
      .reset          (reset),
      .write          (write),
      .writeSSID      (writeSSID),
      .writeHitInfo   (writeHitInfo),
      .read           (read),
      .readSSID       (readSSID),
      .SSID_read      (SSID_read),
      .hitInfo_read   (hitInfo_read),
      .dataValid_read (dataValid_read),
      .busy_read      (busy_read)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatch++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Output monitor: pop an expected hit on every valid cycle.
   always @(negedge clk) begin
      exp_t e;
      checkVal("busy", {31'd0, busy_read}, {31'd0, sb.size() > 0});
      if (dataValid_read) begin
         if (sb.size() == 0) begin
            checkVal("spurious valid", {31'd0, dataValid_read}, 32'd0);
         end else begin
            e = sb.pop_front();
            checkVal("ssid", {24'd0, SSID_read}, {24'd0, e.ssid});
            checkVal("info", {24'd0, hitInfo_read}, {24'd0, e.info});
            checkVal("cycle", cyc, e.cyc);
         end
      end else begin
         checkVal("idle ssid", {24'd0, SSID_read}, 32'd0);
         checkVal("idle info", {24'd0, hitInfo_read}, 32'd0);
      end
   end

   task automatic wrHit(input logic [7:0] s, input logic [7:0] h);
      write = 1'b1;
      writeSSID = s;
      writeHitInfo = h;
      @(posedge clk);
      #1;
      write = 1'b0;
      if (mCnt[s] < 4) begin
         mMem[s][mCnt[s]] = h;
         mCnt[s]++;
      end
   endtask

   task automatic doRead(input logic [7:0] s);
      int n;
      n = mCnt[s];
      readSSID = s;
      read = 1'b1;
      @(posedge clk);
      #1;
      read = 1'b0;
      for (int i = 0; i < n; i++) sb.push_back('{s, mMem[s][i], cyc + 1 + i});
   endtask

   task automatic waitDrain();
      int k;
      k = 0;
      while ((sb.size() != 0 || busy_read) && k < 40) begin
         @(negedge clk);
         #1;
         k++;
      end
      checkVal("drain timeout", {31'd0, k < 40}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   logic [7:0] others [13];

   initial begin
      for (int i = 0; i < 256; i++) mCnt[i] = 0;
      reset = 1'b0;
      write = 1'b0;
      read = 1'b0;
      writeSSID = '0;
      writeHitInfo = '0;
      readSSID = '0;
      repeat (3) @(negedge clk);
      checkVal("reset valid", {31'd0, dataValid_read}, 32'd0);
      checkVal("reset busy", {31'd0, busy_read}, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Empty SSID: nothing streamed.
      doRead(8'h46);
      waitDrain();

      // 23 hits, info = SSID.
      for (int i = 0; i < 4; i++) wrHit(8'h88, 8'h88);
      for (int i = 0; i < 2; i++) begin
         wrHit(8'h80, 8'h80);
         wrHit(8'h44, 8'h44);
         wrHit(8'h41, 8'h41);
      end
      for (int i = 0; i < 13; i++) others[i] = 8'h10 + 8'(i);
      foreach (others[i]) wrHit(others[i], others[i]);
      doRead(8'h88);
      waitDrain();

      // Overflow: fifth hit dropped.
      wrHit(8'h88, 8'h55);
      doRead(8'h88);
      waitDrain();

      // Write then read on the next edge.
      wrHit(8'h2B, 8'h2B);
      doRead(8'h2B);
      waitDrain();

      // Read during a stream is ignored.
      doRead(8'h88);
      @(posedge clk);
      #1;
      readSSID = 8'h44;
      read = 1'b1;
      @(posedge clk);
      #1;
      read = 1'b0;
      waitDrain();

      doRead(8'h44);
      waitDrain();
      doRead(8'h41);
      waitDrain();
      doRead(8'h1C);
      waitDrain();

      // Reset during a stream.
      doRead(8'h88);
      @(posedge clk);
      #2;
      reset = 1'b0;
      sb.delete();
      for (int i = 0; i < 256; i++) mCnt[i] = 0;
      #1;
      checkVal("rst valid", {31'd0, dataValid_read}, 32'd0);
      checkVal("rst busy", {31'd0, busy_read}, 32'd0);
      checkVal("rst ssid", {24'd0, SSID_read}, 32'd0);
      checkVal("rst info", {24'd0, hitInfo_read}, 32'd0);
      @(negedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      doRead(8'h88);
      waitDrain();

      // Counts restart from zero after reset.
      wrHit(8'h88, 8'h77);
      doRead(8'h88);
      waitDrain();

      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
